// File: rtl/shared_dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_pkg
// Description : Types and constants shared by the shared-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package shared_mem_pkg;

    localparam int ID_W        = 8;
    localparam int WORD_ADDR_W = 30;

    typedef enum logic [3:0] {
        AMO_LR   = 4'd0,
        AMO_SC   = 4'd1,
        AMO_SWAP = 4'd2,
        AMO_ADD  = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_MIN  = 4'd7,
        AMO_MAX  = 4'd8,
        AMO_MINU = 4'd9,
        AMO_MAXU = 4'd10
    } amoop_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } shared_mem_state_t;

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic                   we;
        logic                   is_amo;
        amoop_t                 amoop;
        logic [3:0]             mask;
        logic [WORD_ADDR_W-1:0] idx;
        logic [31:0]            wdata;
    } shared_mem_req_t;

    localparam logic [31:0] SC_SUCCESS = 32'd0;
    localparam logic [31:0] SC_FAIL    = 32'd1;

    // Loads and LR finish straight from the read phase; everything else writes.
    function automatic logic needs_write_phase(input logic is_amo, input logic we,
                                               input amoop_t op);
        return is_amo ? (op != AMO_LR) : we;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shared_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : shared_dmem_if
// Description : Flattened per-core request / response bundle of the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface shared_dmem_if #(
    parameter int N_CORES = 2
);
    logic [N_CORES-1:0]    req_valid;
    logic [N_CORES-1:0]    req_we;
    logic [N_CORES-1:0]    req_is_amo;
    logic [N_CORES*4-1:0]  req_amoop;
    logic [N_CORES*4-1:0]  req_mask;
    logic [N_CORES*32-1:0] req_addr;
    logic [N_CORES*32-1:0] req_wdata;
    logic [N_CORES-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic [N_CORES-1:0]    busy;

    modport master (
        output req_valid, req_we, req_is_amo, req_amoop, req_mask, req_addr, req_wdata,
        input  rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_is_amo, req_amoop, req_mask, req_addr, req_wdata,
        output rsp_valid, rsp_rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/shared_dmem_responder_amo_alu.sv
`default_nettype none
// ============================================================================
// Module      : amo_alu
// Description : Combinational AMO datapath: (op, old word, operand) -> new word.
// Revision    : 1.0 - initial release
// ============================================================================
module amo_alu
    import shared_mem_pkg::*;
(
    input  var amoop_t      amoop,
    input  wire logic [31:0] old_val,
    input  wire logic [31:0] operand,
    output logic [31:0]      new_val
);

    always_comb begin
        new_val = operand;
        case (amoop)
            AMO_ADD:  new_val = old_val + operand;
            AMO_XOR:  new_val = old_val ^ operand;
            AMO_AND:  new_val = old_val & operand;
            AMO_OR:   new_val = old_val | operand;
            AMO_MIN:  new_val = ($signed(old_val) < $signed(operand)) ? old_val : operand;
            AMO_MAX:  new_val = ($signed(old_val) > $signed(operand)) ? old_val : operand;
            AMO_MINU: new_val = (old_val < operand) ? old_val : operand;
            AMO_MAXU: new_val = (old_val > operand) ? old_val : operand;
            default:  new_val = operand; // SWAP and SC store the operand as-is
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shared_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : shared_dmem_responder
// Description : Round-robin shared data memory with loads, stores, AMOs, LR/SC.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_dmem_responder
    import shared_mem_pkg::*;
#(
    parameter int N_CORES     = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  wire logic    clk,
    input  wire logic    arst_n,
    shared_dmem_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [WORD_ADDR_W-1:0] IDX_MASK = WORD_ADDR_W'((64'd1 << IDX_W) - 64'd1);

    shared_mem_state_t      r_state;
    shared_mem_req_t        r_req;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [31:0]            r_old_q;
    logic [31:0]            r_rsp_rdata;
    logic [N_CORES-1:0]     r_rsp_valid;
    logic [N_CORES-1:0]     r_resv_valid;
    logic [WORD_ADDR_W-1:0] r_resv_idx [N_CORES];
    logic [31:0]            r_mem [DEPTH_WORDS];

    logic                   w_grant_any;
    logic [PTR_W-1:0]       w_grant_id;
    logic [WORD_ADDR_W-1:0] w_grant_idx;
    logic [IDX_W-1:0]       w_mem_idx;
    logic [N_CORES-1:0]     w_winner_onehot;
    logic                   w_is_sc;
    logic                   w_sc_ok;
    logic                   w_do_write;
    logic [3:0]             w_wr_be;
    logic [31:0]            w_wr_data;
    logic [31:0]            w_alu_out;

    // Scan from the highest offset down so the closest requester at/after rr_ptr wins.
    always_comb begin
        int cand;
        w_grant_any = 1'b0;
        w_grant_id  = r_rr_ptr;
        for (int off = N_CORES - 1; off >= 0; off--) begin
            cand = (int'(r_rr_ptr) + off) % N_CORES;
            if (bus.req_valid[PTR_W'(cand)]) begin
                w_grant_any = 1'b1;
                w_grant_id  = PTR_W'(cand);
            end
        end
    end

    assign w_grant_idx = bus.req_addr[w_grant_id*32 + 2 +: WORD_ADDR_W] & IDX_MASK;
    assign w_mem_idx   = r_req.idx[IDX_W-1:0];
    assign w_is_sc     = r_req.is_amo && (r_req.amoop == AMO_SC);

    always_comb begin
        w_winner_onehot = '0;
        w_sc_ok         = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            w_winner_onehot[i] = (r_req.id == ID_W'(i));
            if (w_winner_onehot[i] && r_resv_valid[i] && (r_resv_idx[i] == r_req.idx))
                w_sc_ok = 1'b1;
        end
    end

    assign w_do_write = (r_state == S_WRITE) &&
                        (r_req.is_amo ? (w_is_sc ? w_sc_ok : 1'b1) : r_req.we);
    assign w_wr_be    = r_req.is_amo ? 4'hF : r_req.mask;
    assign w_wr_data  = r_req.is_amo ? w_alu_out : r_req.wdata;

    amo_alu u_amo_alu (
        .amoop   (r_req.amoop),
        .old_val (r_old_q),
        .operand (r_req.wdata),
        .new_val (w_alu_out)
    );

    // Array is not reset; the write is gated by r_state, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_be[b])
                    r_mem[w_mem_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= S_IDLE;
            r_req        <= '0;
            r_rr_ptr     <= '0;
            r_old_q      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_resv_valid <= '0;
            for (int i = 0; i < N_CORES; i++)
                r_resv_idx[i] <= '0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_req.id     <= ID_W'(w_grant_id);
                        r_req.we     <= bus.req_we[w_grant_id];
                        r_req.is_amo <= bus.req_is_amo[w_grant_id];
                        r_req.amoop  <= amoop_t'(bus.req_amoop[w_grant_id*4 +: 4]);
                        r_req.mask   <= bus.req_mask[w_grant_id*4 +: 4];
                        r_req.idx    <= w_grant_idx;
                        r_req.wdata  <= bus.req_wdata[w_grant_id*32 +: 32];
                        r_rr_ptr     <= (w_grant_id == PTR_W'(N_CORES - 1)) ? '0
                                                                              : w_grant_id + 1'b1;
                        r_state      <= S_READ;
                    end
                end
                S_READ: begin
                    r_old_q <= r_mem[w_mem_idx];
                    if (needs_write_phase(r_req.is_amo, r_req.we, r_req.amoop)) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_rsp_valid <= w_winner_onehot;
                        r_rsp_rdata <= r_mem[w_mem_idx];
                        if (r_req.is_amo) begin
                            for (int i = 0; i < N_CORES; i++) begin
                                if (w_winner_onehot[i]) begin
                                    r_resv_valid[i] <= 1'b1;
                                    r_resv_idx[i]   <= r_req.idx;
                                end
                            end
                        end
                        r_state <= S_RESP;
                    end
                end
                S_WRITE: begin
                    for (int i = 0; i < N_CORES; i++) begin
                        if ((w_do_write && (r_resv_idx[i] == r_req.idx)) ||
                            (w_is_sc && w_winner_onehot[i]))
                            r_resv_valid[i] <= 1'b0;
                    end
                    r_rsp_rdata <= w_is_sc ? (w_sc_ok ? SC_SUCCESS : SC_FAIL) : r_old_q;
                    r_rsp_valid <= w_winner_onehot;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.busy      = bus.req_valid & ~r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_shared_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_dmem_responder
// Description : Self-checking bench with a behavioural word-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_dmem_responder;
    import shared_mem_pkg::*;

    localparam int N_CORES     = 2;
    localparam int DEPTH_WORDS = 1024;
    localparam int TIMEOUT     = 40;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    shared_dmem_if #(.N_CORES(N_CORES)) bus ();

    shared_dmem_responder #(.N_CORES(N_CORES), .DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    logic        t_valid  [N_CORES];
    logic        t_we     [N_CORES];
    logic        t_is_amo [N_CORES];
    amoop_t      t_amoop  [N_CORES];
    logic [3:0]  t_mask   [N_CORES];
    logic [31:0] t_addr   [N_CORES];
    logic [31:0] t_wdata  [N_CORES];

    assign bus.req_valid  = {t_valid[1], t_valid[0]};
    assign bus.req_we     = {t_we[1], t_we[0]};
    assign bus.req_is_amo = {t_is_amo[1], t_is_amo[0]};
    assign bus.req_amoop  = {t_amoop[1], t_amoop[0]};
    assign bus.req_mask   = {t_mask[1], t_mask[0]};
    assign bus.req_addr   = {t_addr[1], t_addr[0]};
    assign bus.req_wdata  = {t_wdata[1], t_wdata[0]};

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word memory keyed by word index plus one reservation per core.
    logic [31:0] m_mem [int];
    bit          m_rv   [N_CORES];
    int          m_ridx [N_CORES];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'(DEPTH_WORDS - 1));
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N_CORES; i++) m_rv[i] = 1'b0;
    endfunction

    function automatic logic [31:0] m_apply(input int c, input logic we, input logic is_amo,
                                            input amoop_t op, input logic [3:0] mask,
                                            input logic [31:0] addr, input logic [31:0] wdata);
        int          x   = widx(addr);
        logic [31:0] old = m_mem.exists(x) ? m_mem[x] : 32'h0;
        logic [31:0] nv  = old;
        logic [31:0] res = old;
        bit          wr  = 1'b0;
        if (!is_amo) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (mask[b]) nv[8*b +: 8] = wdata[8*b +: 8];
                wr = 1'b1;
            end
        end else begin
            wr = 1'b1;
            case (op)
                AMO_LR:   begin wr = 1'b0; m_rv[c] = 1'b1; m_ridx[c] = x; end
                AMO_SC:   begin
                    wr  = m_rv[c] && (m_ridx[c] == x);
                    nv  = wdata;
                    res = wr ? 32'd0 : 32'd1;
                    m_rv[c] = 1'b0;
                end
                AMO_SWAP: nv = wdata;
                AMO_ADD:  nv = old + wdata;
                AMO_XOR:  nv = old ^ wdata;
                AMO_AND:  nv = old & wdata;
                AMO_OR:   nv = old | wdata;
                AMO_MIN:  nv = ($signed(old) <= $signed(wdata)) ? old : wdata;
                AMO_MAX:  nv = ($signed(old) >= $signed(wdata)) ? old : wdata;
                AMO_MINU: nv = (old <= wdata) ? old : wdata;
                AMO_MAXU: nv = (old >= wdata) ? old : wdata;
                default:  nv = wdata;
            endcase
        end
        if (wr) begin
            m_mem[x] = nv;
            for (int i = 0; i < N_CORES; i++)
                if (m_rv[i] && m_ridx[i] == x) m_rv[i] = 1'b0;
        end
        return res;
    endfunction

    // Presents one request on core c and waits (bounded) for its response; lat = -1 on timeout.
    task automatic issue(input int c, input logic we, input logic is_amo, input amoop_t op,
                         input logic [3:0] mask, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat);
        @(negedge clk);
        t_valid[c] = 1'b1; t_we[c] = we; t_is_amo[c] = is_amo; t_amoop[c] = op;
        t_mask[c]  = mask; t_addr[c] = addr; t_wdata[c] = wdata;
        rdata = 'x;
        lat   = -1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (bus.rsp_valid[c]) begin
                rdata = bus.rsp_rdata;
                lat   = k;
                break;
            end
        end
        t_valid[c] = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 2'b00) begin
            n_errors++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid);
        end
        n_checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_rsp_rdata got=%08h exp=00000000", bus.rsp_rdata);
        end
        n_checks++;
        if (bus.busy !== 2'b00) begin
            n_errors++; $display("FAIL reset_busy got=%b exp=00", bus.busy);
        end
        arst_n = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    task automatic test_masked_store_load();
        logic [31:0] rd;
        int lat;
        void'(m_apply(0, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h10, 32'hAABBCCDD));
        issue(0, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h10, 32'hAABBCCDD, rd, lat);
        n_checks++;
        if (lat != 3) begin n_errors++; $display("FAIL store_latency got=%0d exp=3", lat); end
        void'(m_apply(0, 1'b1, 1'b0, AMO_LR, 4'b0011, 32'h10, 32'h00001122));
        issue(0, 1'b1, 1'b0, AMO_LR, 4'b0011, 32'h10, 32'h00001122, rd, lat);
        issue(0, 1'b0, 1'b0, AMO_LR, 4'h0, 32'h10, 32'h0, rd, lat);
        n_checks++;
        if (rd !== 32'hAABB1122) begin
            n_errors++; $display("FAIL masked_load got=%08h exp=AABB1122", rd);
        end
        n_checks++;
        if (lat != 2) begin n_errors++; $display("FAIL load_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_amo_add_max();
        logic [31:0] rd;
        int lat;
        void'(m_apply(0, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h20, 32'h7FFFFFFF));
        issue(0, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h20, 32'h7FFFFFFF, rd, lat);
        void'(m_apply(1, 1'b0, 1'b1, AMO_ADD, 4'h0, 32'h20, 32'h1));
        issue(1, 1'b0, 1'b1, AMO_ADD, 4'h0, 32'h20, 32'h1, rd, lat);
        n_checks++;
        if (rd !== 32'h7FFFFFFF || lat != 3) begin
            n_errors++; $display("FAIL amoadd got=%08h/lat%0d exp=7FFFFFFF/lat3", rd, lat);
        end
        void'(m_apply(1, 1'b0, 1'b1, AMO_MAX, 4'h0, 32'h20, 32'h0));
        issue(1, 1'b0, 1'b1, AMO_MAX, 4'h0, 32'h20, 32'h0, rd, lat);
        n_checks++;
        if (rd !== 32'h80000000) begin
            n_errors++; $display("FAIL amomax_old got=%08h exp=80000000", rd);
        end
        issue(0, 1'b0, 1'b0, AMO_LR, 4'h0, 32'h20, 32'h0, rd, lat);
        n_checks++;
        if (rd !== 32'h00000000) begin
            n_errors++; $display("FAIL amomax_signed got=%08h exp=00000000", rd);
        end
    endtask

    task automatic test_lr_sc();
        logic [31:0] rd;
        int lat;
        void'(m_apply(0, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h40, 32'h11));
        issue(0, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h40, 32'h11, rd, lat);
        void'(m_apply(0, 1'b0, 1'b1, AMO_LR, 4'h0, 32'h40, 32'h0));
        issue(0, 1'b0, 1'b1, AMO_LR, 4'h0, 32'h40, 32'h0, rd, lat);
        n_checks++;
        if (rd !== 32'h11 || lat != 2) begin
            n_errors++; $display("FAIL lr got=%08h/lat%0d exp=00000011/lat2", rd, lat);
        end
        void'(m_apply(0, 1'b0, 1'b1, AMO_SC, 4'h0, 32'h40, 32'h5));
        issue(0, 1'b0, 1'b1, AMO_SC, 4'h0, 32'h40, 32'h5, rd, lat);
        n_checks++;
        if (rd !== SC_SUCCESS) begin n_errors++; $display("FAIL sc_success got=%08h exp=0", rd); end
        issue(1, 1'b0, 1'b0, AMO_LR, 4'h0, 32'h40, 32'h0, rd, lat);
        n_checks++;
        if (rd !== 32'h5) begin n_errors++; $display("FAIL sc_written got=%08h exp=5", rd); end
        void'(m_apply(0, 1'b0, 1'b1, AMO_LR, 4'h0, 32'h40, 32'h0));
        issue(0, 1'b0, 1'b1, AMO_LR, 4'h0, 32'h40, 32'h0, rd, lat);
        void'(m_apply(1, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h40, 32'h99));
        issue(1, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h40, 32'h99, rd, lat);
        void'(m_apply(0, 1'b0, 1'b1, AMO_SC, 4'h0, 32'h40, 32'h6));
        issue(0, 1'b0, 1'b1, AMO_SC, 4'h0, 32'h40, 32'h6, rd, lat);
        n_checks++;
        if (rd !== SC_FAIL) begin n_errors++; $display("FAIL sc_fail got=%08h exp=1", rd); end
        issue(0, 1'b0, 1'b0, AMO_LR, 4'h0, 32'h40, 32'h0, rd, lat);
        n_checks++;
        if (rd !== 32'h99) begin n_errors++; $display("FAIL sc_nowrite got=%08h exp=99", rd); end
    endtask

    task automatic test_round_robin();
        int          order [$];
        logic [31:0] exp_rd [N_CORES];
        logic [1:0]  exp_busy;
        exp_rd[0] = m_mem[widx(32'h10)];
        exp_rd[1] = m_mem[widx(32'h20)];
        for (int i = 0; i < N_CORES; i++) begin
            t_we[i] = 1'b0; t_is_amo[i] = 1'b0; t_amoop[i] = AMO_LR; t_mask[i] = 4'h0;
            t_wdata[i] = 32'h0;
        end
        t_addr[0] = 32'h10;
        t_addr[1] = 32'h20;
        arst_n = 1'b0;
        @(negedge clk);
        t_valid[0] = 1'b1;
        t_valid[1] = 1'b1;
        do_reset();
        for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
            @(negedge clk);
            exp_busy = {t_valid[1], t_valid[0]} & ~bus.rsp_valid;
            n_checks++;
            if (bus.busy !== exp_busy) begin
                n_errors++; $display("FAIL rr_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy);
            end
            for (int i = 0; i < N_CORES; i++) begin
                if (bus.rsp_valid[i]) begin
                    order.push_back(i);
                    n_checks++;
                    if (bus.rsp_rdata !== exp_rd[i]) begin
                        n_errors++;
                        $display("FAIL rr_rdata core%0d got=%08h exp=%08h", i, bus.rsp_rdata, exp_rd[i]);
                    end
                end
            end
        end
        t_valid[0] = 1'b0;
        t_valid[1] = 1'b0;
        n_checks++;
        if (order.size() != 4) begin
            n_errors++; $display("FAIL rr_count got=%0d exp=4", order.size());
        end
        for (int k = 0; k < order.size() && k < 4; k++) begin
            n_checks++;
            if (order[k] != k % 2) begin
                n_errors++; $display("FAIL rr_order slot%0d got=%0d exp=%0d", k, order[k], k % 2);
            end
        end
    endtask

    task automatic test_atomicity();
        logic [31:0] rd0, rd1, rd, opnd;
        int lat0, lat1, lat;
        opnd = $urandom;
        void'(m_apply(1, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h80, 32'h3));
        issue(1, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h80, 32'h3, rd, lat);
        void'(m_apply(0, 1'b0, 1'b1, AMO_SWAP, 4'h0, 32'h80, opnd));
        void'(m_apply(1, 1'b0, 1'b1, AMO_ADD, 4'h0, 32'h80, 32'h1));
        fork
            issue(0, 1'b0, 1'b1, AMO_SWAP, 4'h0, 32'h80, opnd, rd0, lat0);
            issue(1, 1'b0, 1'b1, AMO_ADD, 4'h0, 32'h80, 32'h1, rd1, lat1);
        join
        n_checks++;
        if (rd0 !== 32'h3) begin n_errors++; $display("FAIL atom_swap got=%08h exp=00000003", rd0); end
        n_checks++;
        if (rd1 !== opnd) begin n_errors++; $display("FAIL atom_add got=%08h exp=%08h", rd1, opnd); end
        issue(0, 1'b0, 1'b0, AMO_LR, 4'h0, 32'h80, 32'h0, rd, lat);
        n_checks++;
        if (rd !== opnd + 32'd1) begin
            n_errors++; $display("FAIL atom_final got=%08h exp=%08h", rd, opnd + 32'd1);
        end
    endtask

    task automatic test_reset_mid_amo();
        logic [31:0] rd;
        int lat;
        bit seen;
        void'(m_apply(0, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h90, 32'h7));
        issue(0, 1'b1, 1'b0, AMO_LR, 4'hF, 32'h90, 32'h7, rd, lat);
        @(negedge clk);
        t_valid[0] = 1'b1; t_we[0] = 1'b0; t_is_amo[0] = 1'b1; t_amoop[0] = AMO_SWAP;
        t_mask[0] = 4'h0; t_addr[0] = 32'h90; t_wdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        arst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) seen = 1'b1;
        end
        t_valid[0] = 1'b0;
        arst_n = 1'b1;
        m_reset();
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_errors++; $display("FAIL midreset_rsp got=1 exp=0"); end
        issue(0, 1'b0, 1'b0, AMO_LR, 4'h0, 32'h90, 32'h0, rd, lat);
        n_checks++;
        if (rd !== 32'h7) begin n_errors++; $display("FAIL midreset_mem got=%08h exp=00000007", rd); end
    endtask

    task automatic test_random_back_to_back();
        int          pool [4] = '{32'h100, 32'h101, 32'h2A0, 32'h3FF};
        logic [31:0] rd, exp, addr, wd;
        logic [3:0]  mask;
        logic        we, amo;
        amoop_t      op;
        int          c, kind, lat, exp_lat;
        for (int p = 0; p < 4; p++) begin
            wd = $urandom;
            addr = 32'(pool[p]) << 2;
            void'(m_apply(0, 1'b1, 1'b0, AMO_LR, 4'hF, addr, wd));
            issue(0, 1'b1, 1'b0, AMO_LR, 4'hF, addr, wd, rd, lat);
        end
        for (int n = 0; n < 60; n++) begin
            c    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 5));
            addr = ($urandom & 32'hFFFF_F000) | (32'(pool[$urandom_range(0, 3)]) << 2)
                   | 32'($urandom_range(0, 3));
            wd   = $urandom;
            mask = 4'($urandom_range(1, 15));
            we = 1'b0; amo = 1'b1; op = AMO_LR;
            case (kind)
                0: amo = 1'b0;
                1: begin amo = 1'b0; we = 1'b1; end
                2: op = AMO_LR;
                3: op = AMO_SC;
                default: op = amoop_t'(4'($urandom_range(2, 10)));
            endcase
            exp = m_apply(c, we, amo, op, mask, addr, wd);
            issue(c, we, amo, op, mask, addr, wd, rd, lat);
            exp_lat = ((!amo && !we) || (amo && op == AMO_LR)) ? 2 : 3;
            n_checks++;
            if (lat != exp_lat) begin
                n_errors++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, exp_lat);
            end
            if (amo || !we) begin
                n_checks++;
                if (rd !== exp) begin
                    n_errors++;
                    $display("FAIL rand_rdata n=%0d core%0d kind=%0d op=%0d got=%08h exp=%08h",
                             n, c, kind, op, rd, exp);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N_CORES; i++) begin
            t_valid[i] = 1'b0; t_we[i] = 1'b0; t_is_amo[i] = 1'b0; t_amoop[i] = AMO_LR;
            t_mask[i] = 4'h0; t_addr[i] = 32'h0; t_wdata[i] = 32'h0;
        end
        arst_n = 1'b0;
        test_reset();
        test_masked_store_load();
        test_amo_add_max();
        test_lr_sc();
        test_round_robin();
        test_atomicity();
        test_reset_mid_amo();
        test_random_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/shared_dmem_responder.md
Name: shared_dmem_responder

Overview:
- Memory-side end of the core-to-shared-memory interface: the responder for the memory-stage request (mask, address, write data, AMO op).
- Arbitrates N_CORES requesters round-robin, services plain loads and stores, executes AMO read-modify-write atomically, tracks LR/SC reservations, and returns read data plus a busy indication that drives the core's amo_busy stall.
- Contains a word-organised data array.

Parameters:
- N_CORES, 2, number of requesting cores.
- DEPTH_WORDS, 1024, data array depth in 32-bit words; power of two.
- IDX_W, $clog2(DEPTH_WORDS), word index width (derived, localparam).

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- req_valid  in  N_CORES  per-core request; held stable until that core's rsp_valid
- req_we  in  N_CORES  store (ignored when req_is_amo)
- req_is_amo  in  N_CORES  atomic request
- req_amoop  in  N_CORES*4  amoop_t per core
- req_mask  in  N_CORES*4  byte-lane mask for stores
- req_addr  in  N_CORES*32  byte address; bits [1:0] ignored
- req_wdata  in  N_CORES*32  store / AMO operand
- rsp_valid  out  N_CORES  one-cycle completion pulse
- rsp_rdata  out  32  load data, AMO old value, or SC status; valid with any rsp_valid bit
- busy  out  N_CORES  req_valid[i] and not rsp_valid[i]

Behaviour:
- Reset is asynchronous, active-low. It forces:
  - state to S_IDLE, rsp_valid to 0, rsp_rdata to 0;
  - the round-robin pointer to core 0;
  - all reservations invalid.
- Array contents are not reset.
- Word index: addr[2 +: IDX_W]. Upper bits alias.
- FSM states: S_IDLE, S_READ, S_WRITE, S_RESP.
- S_IDLE:
  - If any req_valid, grant the lowest index at or after rr_ptr, wrapping.
  - Latch the winner's id, op, mask, index and wdata, then go to S_READ.
  - rr_ptr becomes winner+1, mod N_CORES.
- S_READ: old_q is registered from the array. Next state:
  - load or LR goes to S_RESP;
  - store, SC and any other AMO go to S_WRITE.
- S_WRITE:
  - Store: write bytes whose mask bit is set.
  - SC:
    - Success requires the winner's reservation to be valid with a matching index.
    - On success, write the full word and set the result to 0.
    - On failure, skip the write and set the result to 1.
    - The winner's reservation is cleared either way.
  - Other AMOs: write amo_result(old_q, wdata) as a full word.
    - SWAP gives wdata.
    - ADD wraps mod 2^32.
    - XOR, AND, OR are bitwise.
    - MIN and MAX compare signed.
    - MINU and MAXU compare unsigned.
  - Go to S_RESP.
- S_RESP:
  - rsp_valid[winner] = 1.
  - rsp_rdata = old_q for load and AMO, or the SC result.
  - Go to S_IDLE.
- Latency, counted from the cycle the request is sampled in S_IDLE:
  - load and LR: rsp_valid in cycle +2;
  - store, SC and AMO: rsp_valid in cycle +3.
- Throughput: one request per 3–4 cycles.
- A core may present its next request in the cycle after its rsp_valid.
- Atomicity: no other request is sampled between S_READ and S_WRITE of the same transaction.
- Reservations (one per core):
  - LR sets valid and records the index.
  - Any completed array write (store, successful SC, AMO) to index X clears every core's reservation on X, including the writer's.
  - LR to a new address replaces the old reservation.
- Simultaneous requests: arbitration only in S_IDLE. Losers see busy stay high; their inputs are not sampled.
- Request withdrawn before grant: ignored. Withdrawing after grant is illegal; the transaction still completes.
- Reset mid-transaction: an in-flight write not yet performed in S_WRITE is discarded, and no rsp_valid is issued.

Decomposition:
- amoop_t reuses the existing AMO typedef: LR, SC, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU, encoded in 4 bits.
- New package shared_mem_pkg holds:
  - shared_mem_state_t, the FSM enum;
  - shared_mem_req_t, the latched request struct (id, we, is_amo, amoop, mask, idx, wdata);
  - constants SC_SUCCESS = 0 and SC_FAIL = 1.
- One combinational sub-module, amo_alu, computes (amoop, old, operand) -> new word.

Test Plan:
- Masked store then load:
  - Core0 stores 0xAABBCCDD to 0x10 with mask 4'b1111.
  - Core0 then stores 0x00001122 with mask 4'b0011.
  - Load 0x10 returns 0xAABB1122; load rsp_valid arrives exactly 2 cycles after sampling.
- AMOADD:
  - Memory[0x20] = 0x7FFFFFFF; core1 AMOADD with 1.
  - rsp_rdata = 0x7FFFFFFF and memory becomes 0x80000000.
  - A follow-up AMOMAX with 0 returns 0x80000000 and leaves 0x00000000 stored (signed compare).
- LR/SC success and failure:
  - Core0 LR 0x40, then SC 0x40 with 5: rdata 0 and memory 5.
  - Core0 LR 0x40, core1 stores 0x40, then core0 SC 0x40: rdata 1 and memory unchanged.
- Round-robin:
  - Both cores hold req_valid from reset.
  - Grants alternate 0, 1, 0, 1.
  - busy of the waiting core stays high until its own rsp_valid.
- Same-cycle atomicity:
  - Core0 AMOSWAP and core1 AMOADD 1 on 0x80 (initially 3), issued together.
  - Core0 gets 3; core1 gets the swap operand; final value is operand+1.
- Reset mid-AMO:
  - Assert arst_n low during S_READ of an AMOSWAP on 0x90 (value 7).
  - rsp_valid stays 0, memory stays 7, and a post-reset load returns 7.
